// File: rtl/ex_branch_resolve_feedback_if.sv
// Bundle between IF (branch issue), EX (branch resolution) and the BHT update port.
// The slave modport is the resolve/feedback block; the master modport drives it.
interface ex_branch_resolve_feedback_if #(
  parameter int PTR_W = 2
);
  logic             if_push;
  logic [31:0]      if_push_pc;
  logic             if_push_take;
  logic [31:0]      if_push_target;
  logic             stash_full;
  logic             ex_resolve;
  logic             ex_take;
  logic [31:0]      ex_target;
  logic             pc_jmp_feedback;
  logic             pc_jmp_take;
  logic [31:0]      pc_stash_base;
  logic             mispredict;
  logic [31:0]      redirect_pc;
  logic [PTR_W:0]   stash_count;
  logic             overflow_err;
  logic             underflow_err;

  modport slave (
    input  if_push, if_push_pc, if_push_take, if_push_target,
    input  ex_resolve, ex_take, ex_target,
    output stash_full, pc_jmp_feedback, pc_jmp_take, pc_stash_base,
    output mispredict, redirect_pc, stash_count, overflow_err, underflow_err
  );

  modport master (
    output if_push, if_push_pc, if_push_take, if_push_target,
    output ex_resolve, ex_take, ex_target,
    input  stash_full, pc_jmp_feedback, pc_jmp_take, pc_stash_base,
    input  mispredict, redirect_pc, stash_count, overflow_err, underflow_err
  );
endinterface

// File: rtl/ex_branch_resolve_feedback.sv
// In-order stash of predicted branches; resolves the oldest against the EX outcome,
// emits the BHT update and, on a misprediction, a redirect plus a full flush.
module ex_branch_resolve_feedback #(
  parameter int          DEPTH   = 4,
  parameter int          PTR_W   = 2,
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input logic                          clk,
  input logic                          reset,
  ex_branch_resolve_feedback_if.slave  bus
);

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fill_state_t;

  fill_state_t      state_reg, state_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;

  logic [31:0]      pc_mem     [DEPTH];
  logic             take_mem   [DEPTH];
  logic [31:0]      target_mem [DEPTH];
  logic [DEPTH-1:0] wr_en;

  logic             feedback_reg, fb_take_reg, mispredict_reg;
  logic [31:0]      base_reg, redirect_reg;
  logic             overflow_reg, underflow_reg;

  logic             full, empty;
  logic             resolve_valid, mispred, push_ok;
  logic             overflow_set, underflow_set;
  logic [31:0]      head_pc, head_target, redirect_calc;
  logic             head_take;

  // Fill level is tracked both as a count and as a coarse state; the state drives the
  // full/empty decode so the accept logic does not depend on a wide compare.
  assign full  = (state_reg == ST_FULL);
  assign empty = (state_reg == ST_EMPTY);

  assign head_pc     = pc_mem[head_reg];
  assign head_take   = take_mem[head_reg];
  assign head_target = target_mem[head_reg];

  always_comb begin
    resolve_valid = 1'b0;
    mispred       = 1'b0;
    push_ok       = 1'b0;
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
    redirect_calc = head_pc + PC_STEP;
    head_next     = head_reg;
    tail_next     = tail_reg;
    count_next    = count_reg;
    state_next    = state_reg;

    resolve_valid = bus.ex_resolve && !empty;
    underflow_set = bus.ex_resolve && empty;
    mispred       = resolve_valid &&
                    ((head_take != bus.ex_take) ||
                     (bus.ex_take && (head_target != bus.ex_target)));
    if (bus.ex_take) begin
      redirect_calc = bus.ex_target;
    end

    // A push alongside a mispredict is wrong-path: dropped silently, not an overflow.
    push_ok      = bus.if_push && !full && !mispred;
    overflow_set = bus.if_push && full && !mispred;

    if (mispred) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (push_ok) begin
        tail_next = tail_reg + PTR_W'(1);
      end
      if (resolve_valid) begin
        head_next = head_reg + PTR_W'(1);
      end
      count_next = count_reg + (PTR_W+1)'(push_ok) - (PTR_W+1)'(resolve_valid);
    end

    if (count_next == '0) begin
      state_next = ST_EMPTY;
    end else if (count_next == DEPTH_CNT) begin
      state_next = ST_FULL;
    end else begin
      state_next = ST_PARTIAL;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok && (tail_reg == PTR_W'(gi));
    end
  endgenerate

  // Entry payload needs no reset: validity is defined purely by head/count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) begin
        pc_mem[i]     <= bus.if_push_pc;
        take_mem[i]   <= bus.if_push_take;
        target_mem[i] <= bus.if_push_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      feedback_reg   <= 1'b0;
      fb_take_reg    <= 1'b0;
      base_reg       <= '0;
      mispredict_reg <= 1'b0;
      redirect_reg   <= '0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      feedback_reg   <= resolve_valid;
      mispredict_reg <= mispred;
      if (resolve_valid) begin
        fb_take_reg  <= bus.ex_take;
        base_reg     <= head_pc;
        redirect_reg <= redirect_calc;
      end
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end
      if (underflow_set) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign bus.stash_full      = (count_reg == DEPTH_CNT);
  assign bus.stash_count     = count_reg;
  assign bus.pc_jmp_feedback = feedback_reg;
  assign bus.pc_jmp_take     = fb_take_reg;
  assign bus.pc_stash_base   = base_reg;
  assign bus.mispredict      = mispredict_reg;
  assign bus.redirect_pc     = redirect_reg;
  assign bus.overflow_err    = overflow_reg;
  assign bus.underflow_err   = underflow_reg;

endmodule

// File: tb/tb_ex_branch_resolve_feedback.sv
// Directed bench for ex_branch_resolve_feedback: each task drives one scenario and
// compares outputs one cycle after the edge that consumed the stimulus.
module tb_ex_branch_resolve_feedback;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  ex_branch_resolve_feedback_if #(.PTR_W(2)) bus ();

  ex_branch_resolve_feedback #(
    .DEPTH(4),
    .PTR_W(2),
    .PC_STEP(32'd4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus; returns 1 ns after the consuming edge.
  task automatic drive(input logic push, input logic [31:0] pc, input logic ptake,
                       input logic [31:0] ptgt, input logic res, input logic etake,
                       input logic [31:0] etgt);
    bus.if_push        = push;
    bus.if_push_pc     = pc;
    bus.if_push_take   = ptake;
    bus.if_push_target = ptgt;
    bus.ex_resolve     = res;
    bus.ex_take        = etake;
    bus.ex_target      = etgt;
    @(posedge clk);
    #1;
    $display("txn t=%0t push=%0b pc=%h ptake=%0b ptgt=%h resolve=%0b etake=%0b etgt=%h -> cnt=%0d fb=%0b mp=%0b base=%h redir=%h",
             $time, push, pc, ptake, ptgt, res, etake, etgt, bus.stash_count,
             bus.pc_jmp_feedback, bus.mispredict, bus.pc_stash_base, bus.redirect_pc);
    bus.if_push    = 1'b0;
    bus.ex_resolve = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    n_cmp++; if (bus.stash_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", bus.stash_count); end
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b0) begin n_fail++; $display("FAIL reset_feedback got %0b want 0", bus.pc_jmp_feedback); end
    n_cmp++; if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got %0b want 0", bus.mispredict); end
    n_cmp++; if (bus.stash_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", bus.stash_full); end
    n_cmp++; if (bus.pc_stash_base !== 32'h0) begin n_fail++; $display("FAIL reset_base got %h want 0", bus.pc_stash_base); end
    n_cmp++; if (bus.redirect_pc !== 32'h0) begin n_fail++; $display("FAIL reset_redirect got %h want 0", bus.redirect_pc); end
    n_cmp++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL reset_errs got %0b%0b want 00", bus.overflow_err, bus.underflow_err); end
  endtask

  task automatic test_single();
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.stash_count !== 3'd1) begin n_fail++; $display("FAIL single_count_push got %0d want 1", bus.stash_count); end
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b0) begin n_fail++; $display("FAIL single_no_fb got %0b want 0", bus.pc_jmp_feedback); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b1) begin n_fail++; $display("FAIL single_fb got %0b want 1", bus.pc_jmp_feedback); end
    n_cmp++; if (bus.pc_jmp_take !== 1'b1) begin n_fail++; $display("FAIL single_take got %0b want 1", bus.pc_jmp_take); end
    n_cmp++; if (bus.pc_stash_base !== 32'h100) begin n_fail++; $display("FAIL single_base got %h want 00000100", bus.pc_stash_base); end
    n_cmp++; if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL single_mp got %0b want 0", bus.mispredict); end
    n_cmp++; if (bus.stash_count !== 3'd0) begin n_fail++; $display("FAIL single_count got %0d want 0", bus.stash_count); end
    n_cmp++; if (bus.redirect_pc !== 32'h200) begin n_fail++; $display("FAIL single_redirect got %h want 00000200", bus.redirect_pc); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b0) begin n_fail++; $display("FAIL single_fb_pulse got %0b want 0", bus.pc_jmp_feedback); end
    n_cmp++; if (bus.pc_stash_base !== 32'h100) begin n_fail++; $display("FAIL single_base_hold got %h want 00000100", bus.pc_stash_base); end
  endtask

  task automatic test_dir_mispredict();
    drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL dir_mp got %0b want 1", bus.mispredict); end
    n_cmp++; if (bus.redirect_pc !== 32'h44) begin n_fail++; $display("FAIL dir_redirect got %h want 00000044", bus.redirect_pc); end
    n_cmp++; if (bus.pc_stash_base !== 32'h40) begin n_fail++; $display("FAIL dir_base got %h want 00000040", bus.pc_stash_base); end
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b1) begin n_fail++; $display("FAIL dir_fb got %0b want 1", bus.pc_jmp_feedback); end
    n_cmp++; if (bus.pc_jmp_take !== 1'b0) begin n_fail++; $display("FAIL dir_take got %0b want 0", bus.pc_jmp_take); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL dir_mp_pulse got %0b want 0", bus.mispredict); end
  endtask

  task automatic test_target_flush();
    drive(1'b1, 32'h10, 1'b1, 32'h30, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h14, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h18, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.stash_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got %0d want 3", bus.stash_count); end
    drive(1'b1, 32'h1C, 1'b0, 32'h0,  1'b1, 1'b1, 32'h34);
    n_cmp++; if (bus.mispredict !== 1'b1) begin n_fail++; $display("FAIL flush_mp got %0b want 1", bus.mispredict); end
    n_cmp++; if (bus.redirect_pc !== 32'h34) begin n_fail++; $display("FAIL flush_redirect got %h want 00000034", bus.redirect_pc); end
    n_cmp++; if (bus.pc_stash_base !== 32'h10) begin n_fail++; $display("FAIL flush_base got %h want 00000010", bus.pc_stash_base); end
    n_cmp++; if (bus.stash_count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d want 0", bus.stash_count); end
    n_cmp++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL flush_overflow got %0b want 0", bus.overflow_err); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] pcs [5];
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      if (i == 3) begin
        n_cmp++; if (bus.stash_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %0b want 1", bus.stash_full); end
        n_cmp++; if (bus.overflow_err !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf got %0b want 0", bus.overflow_err); end
      end
    end
    n_cmp++; if (bus.overflow_err !== 1'b1) begin n_fail++; $display("FAIL full_overflow got %0b want 1", bus.overflow_err); end
    n_cmp++; if (bus.stash_count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", bus.stash_count); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (bus.pc_stash_base !== 32'h1000 + 32'(i * 4)) begin n_fail++; $display("FAIL full_order[%0d] got %h want %h", i, bus.pc_stash_base, 32'h1000 + 32'(i * 4)); end
      n_cmp++; if (bus.mispredict !== 1'b0 || bus.pc_jmp_feedback !== 1'b1) begin n_fail++; $display("FAIL full_fb[%0d] got fb=%0b mp=%0b want fb=1 mp=0", i, bus.pc_jmp_feedback, bus.mispredict); end
    end
    n_cmp++; if (bus.stash_full !== 1'b0 || bus.stash_count !== 3'd0) begin n_fail++; $display("FAIL full_drain got full=%0b cnt=%0d want 0/0", bus.stash_full, bus.stash_count); end
    // Wrap: A,B,C fill slots 0..2; D,E land in slots 3 and 0.
    pcs[0] = 32'h2000; pcs[1] = 32'h2004; pcs[2] = 32'h2008; pcs[3] = 32'h200C; pcs[4] = 32'h2010;
    for (int i = 0; i < 3; i++) drive(1'b1, pcs[i], 1'b1, pcs[i] + 32'h100, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, pcs[0] + 32'h100);
    n_cmp++; if (bus.pc_stash_base !== pcs[0]) begin n_fail++; $display("FAIL wrap_order[0] got %h want %h", bus.pc_stash_base, pcs[0]); end
    drive(1'b1, pcs[3], 1'b1, pcs[3] + 32'h100, 1'b0, 1'b0, 32'h0);
    drive(1'b1, pcs[4], 1'b1, pcs[4] + 32'h100, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.stash_count !== 3'd4) begin n_fail++; $display("FAIL wrap_count got %0d want 4", bus.stash_count); end
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, pcs[i] + 32'h100);
      n_cmp++; if (bus.pc_stash_base !== pcs[i] || bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL wrap_order[%0d] got %h mp=%0b want %h mp=0", i, bus.pc_stash_base, bus.mispredict, pcs[i]); end
    end
  endtask

  task automatic test_underflow_and_overlap();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b0) begin n_fail++; $display("FAIL underflow_fb got %0b want 0", bus.pc_jmp_feedback); end
    n_cmp++; if (bus.underflow_err !== 1'b1) begin n_fail++; $display("FAIL underflow_err got %0b want 1", bus.underflow_err); end
    n_cmp++; if (bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL underflow_mp got %0b want 0", bus.mispredict); end
    drive(1'b1, 32'h3000, 1'b1, 32'h3100, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h3004, 1'b1, 32'h3104, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h3008, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3100);
    n_cmp++; if (bus.stash_count !== 3'd2) begin n_fail++; $display("FAIL overlap_count got %0d want 2", bus.stash_count); end
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b1 || bus.pc_stash_base !== 32'h3000) begin n_fail++; $display("FAIL overlap_fb got fb=%0b base=%h want fb=1 base=00003000", bus.pc_jmp_feedback, bus.pc_stash_base); end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3104);
    n_cmp++; if (bus.pc_stash_base !== 32'h3004 || bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL overlap_next got base=%h mp=%0b want 00003004 mp=0", bus.pc_stash_base, bus.mispredict); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h4000, 1'b1, 32'h4100, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 32'h4004, 1'b1, 32'h4104, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.stash_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", bus.stash_count); end
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    reset = 1'b0;
    n_cmp++; if (bus.stash_count !== 3'd0) begin n_fail++; $display("FAIL mid_count got %0d want 0", bus.stash_count); end
    n_cmp++; if (bus.pc_jmp_feedback !== 1'b0 || bus.mispredict !== 1'b0) begin n_fail++; $display("FAIL mid_strobes got fb=%0b mp=%0b want 0/0", bus.pc_jmp_feedback, bus.mispredict); end
    n_cmp++; if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin n_fail++; $display("FAIL mid_errs got ovf=%0b unf=%0b want 0/0", bus.overflow_err, bus.underflow_err); end
    n_cmp++; if (bus.pc_stash_base !== 32'h0) begin n_fail++; $display("FAIL mid_base got %h want 0", bus.pc_stash_base); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.if_push = 1'b0; bus.if_push_pc = '0; bus.if_push_take = 1'b0; bus.if_push_target = '0;
    bus.ex_resolve = 1'b0; bus.ex_take = 1'b0; bus.ex_target = '0;
    test_reset();
    test_single();
    test_dir_mispredict();
    test_target_flush();
    test_full_wrap();
    test_underflow_and_overlap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_branch_resolve_feedback.md
Name: ex_branch_resolve_feedback

Overview:
EX-side counterpart of the IF branch history table. It stashes every branch/jump IF issues together with its prediction, resolves stashed entries in order as EX computes the real outcome, and drives the BHT update port (pc_jmp_feedback / pc_jmp_take / pc_stash_base). On a misprediction it also raises a redirect with the correct PC and flushes all younger stashed entries.

Parameters:
DEPTH, 4, number of in-flight branch entries; power of two, at least 2.
PTR_W, 2, log2(DEPTH).
PC_STEP, 32'd4, fall-through increment for not-taken redirect.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high; clears all state.
if_push  input  1  IF issued a branch/jump this cycle.
if_push_pc  input  32  PC of that branch (the BHT index base).
if_push_take  input  1  predicted take bit from the BHT.
if_push_target  input  32  predicted target (valid when if_push_take=1).
stash_full  output  1  count==DEPTH (combinational from count).
ex_resolve  input  1  EX resolved the oldest outstanding branch.
ex_take  input  1  actual outcome.
ex_target  input  32  actual target (valid when ex_take=1).
pc_jmp_feedback  output  1  registered one-cycle BHT update strobe.
pc_jmp_take  output  1  registered actual outcome.
pc_stash_base  output  32  registered PC of the resolved branch.
mispredict  output  1  registered one-cycle redirect strobe.
redirect_pc  output  32  registered correct next PC.
stash_count  output  PTR_W+1  entries held.
overflow_err  output  1  sticky; push while full.
underflow_err  output  1  sticky; resolve while empty.

Behaviour:
- Reset (synchronous): head, tail, count = 0; all outputs 0 on the next edge; error flags cleared; an in-flight resolve in the same cycle is discarded.
- Storage: circular buffer of {pc, take, target}; head = oldest. Pointers wrap modulo DEPTH.
- Push: accepted iff count<DEPTH at the start of the cycle. A push while full is dropped and sets overflow_err. No bypass through a same-cycle resolve.
- Resolve: acts on the head entry. It is evaluated only when count>0 at the start of the cycle. If count==0, the resolve is ignored, underflow_err is set, and no feedback is issued.
- Mispredict condition: head.take != ex_take, OR (ex_take && head.target != ex_target).
- Latency: all of pc_jmp_feedback, pc_jmp_take, pc_stash_base, mispredict and redirect_pc update on the edge that accepts ex_resolve. They are visible in the following cycle for exactly one cycle. The strobes are 0 otherwise; the data outputs hold their last value.
- pc_jmp_feedback=1 for every valid resolve, correct or not. pc_jmp_take=ex_take; pc_stash_base=head.pc.
- redirect_pc = ex_target if ex_take, else head.pc+PC_STEP (32-bit wrap).
- Flush: on a mispredict, head, tail and count all go to 0. A push in the same cycle is dropped because it is wrong-path; this does not set overflow_err.
- Push and correct resolve in the same cycle: count unchanged, both pointers advance. Push is still blocked if the buffer was full at cycle start.
- The FSM is implicit in count: EMPTY (0), PARTIAL, FULL (DEPTH). Transitions:
  - push only: +1
  - resolve only: -1
  - both: hold
  - mispredict: to EMPTY.

Test Plan:
- Reset then single flow: push pc=0x100 take=1 tgt=0x200; resolve take=1 tgt=0x200 -> next cycle feedback=1, take=1, base=0x100, mispredict=0, count=0.
- Direction mispredict: push 0x40 take=1 tgt=0x80; resolve take=0 -> mispredict=1, redirect_pc=0x44, base=0x40, feedback=1.
- Target mispredict plus flush: push 0x10 (T,0x30), 0x14, 0x18; resolve T tgt 0x34 -> mispredict=1, redirect=0x34, count=0; a same-cycle push is dropped and overflow_err stays 0.
- Full/wrap: push 5 entries with DEPTH=4 -> stash_full=1, 5th dropped, overflow_err=1. Resolve 4 correctly -> bases emitted in order 1..4. Then push/resolve 3 more to wrap the pointers, with order preserved.
- Resolve with count=0 -> no feedback, underflow_err=1. Simultaneous push+correct resolve at count=2 -> count stays 2.
- Reset mid-operation with count=3 and a resolve asserted -> next cycle count=0, feedback=0, mispredict=0, error flags 0.
